// File: rtl/spi_top.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_top / spi_ram : SPI slave front-end bridging to a 256x8 RAM        |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+

module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  logic [7:0]           Mem [0:MEM_DEPTH-1];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (din[9:8])
          2'b00: wr_addr <= din[ADDR_SIZE-1:0];
          2'b10: rd_addr <= din[ADDR_SIZE-1:0];
          2'b11: begin
            dout     <= Mem[rd_addr];
            tx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Storage is never cleared so a preloaded image survives reset.
  always_ff @(posedge clk) begin
    if (!rst_n && rx_valid && (din[9:8] == 2'b01)) begin
      Mem[wr_addr] <= din[7:0];
    end
  end

endmodule

module spi_top #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MOSI,
  output logic MISO,
  input  logic SS_n
);

  localparam logic [3:0] FRAME_BITS = 4'd10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] bit_cnt;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       rd_addr_flag;
  logic [7:0] tx_shift;
  logic [2:0] tx_left;
  logic       in_frame;

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  // The command bit is decoded directly out of IDLE, so CHK_CMD is never dwelt in.
  always_comb begin
    state_nxt = state;
    in_frame  = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!MOSI)             state_nxt = WRITE;
          else if (rd_addr_flag) state_nxt = READ_DATA;
          else                   state_nxt = READ_ADD;
        end
        CHK_CMD: state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      bit_cnt      <= 4'd0;
      rx_data      <= 10'd0;
      rx_valid     <= 1'b0;
      rd_addr_flag <= 1'b0;
      MISO         <= 1'b0;
      tx_shift     <= 8'h00;
      tx_left      <= 3'd0;
    end else if (SS_n) begin
      bit_cnt  <= 4'd0;
      rx_valid <= 1'b0;
      MISO     <= 1'b0;
      tx_left  <= 3'd0;
    end else begin
      rx_valid <= 1'b0;
      if (in_frame && (bit_cnt != FRAME_BITS)) begin
        rx_data <= {rx_data[8:0], MOSI};
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == FRAME_BITS - 4'd1) begin
          rx_valid <= 1'b1;
          if (state == READ_ADD)  rd_addr_flag <= 1'b1;
          if (state == READ_DATA) rd_addr_flag <= 1'b0;
        end
      end
      // Read byte goes out MSB first, starting the cycle after the RAM answers.
      if ((state == READ_DATA) && tx_valid) begin
        MISO     <= tx_data[7];
        tx_shift <= {tx_data[6:0], 1'b0};
        tx_left  <= 3'd7;
      end else if (tx_left != 3'd0) begin
        MISO     <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
        tx_left  <= tx_left - 3'd1;
      end else begin
        MISO <= 1'b0;
      end
    end
  end

  spi_ram #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) Memory (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (rx_data),
    .rx_valid(rx_valid),
    .dout    (tx_data),
    .tx_valid(tx_valid)
  );

endmodule
`default_nettype wire

// File: tb/tb_spi_top.sv
`default_nettype none
// tb_spi_top: directed self-checking bench for the SPI slave + RAM.
module tb_spi_top;

  logic clk;
  logic rst_n;
  logic MOSI;
  logic MISO;
  logic SS_n;

  int total;
  int bad;

  spi_top #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .MOSI (MOSI),
    .MISO (MISO),
    .SS_n (SS_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends 11 bits (command + 10), holds SS_n low for 'extra' more cycles
  // capturing MISO, then raises SS_n and samples MISO once more.
  task automatic send_frame(input logic [10:0] bits, input int extra, input logic extra_bit,
                            output logic [7:0] rbyte, output logic pre_zero, output logic tail);
    rbyte    = 8'h00;
    pre_zero = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = bits[i];
    end
    for (int k = 0; k < extra; k++) begin
      @(negedge clk);
      if (k < 2) pre_zero = pre_zero & (MISO === 1'b0);
      else       rbyte = {rbyte[6:0], MISO};
      MOSI = extra_bit;
    end
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
    tail = MISO;
  endtask

  task automatic send_partial(input logic [10:0] bits, input int n);
    for (int i = 10; i > 10 - n; i--) begin
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = bits[i];
    end
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] rb;
    logic pz, tl;
    send_frame({1'b0, 2'b00, addr}, 0, 1'b0, rb, pz, tl);
    send_frame({1'b0, 2'b01, data}, 0, 1'b0, rb, pz, tl);
  endtask

  task automatic do_read(input logic [7:0] addr, output logic [7:0] rb, output logic pz, output logic tl);
    send_frame({1'b1, 2'b10, addr}, 0, 1'b0, rb, pz, tl);
    send_frame({1'b1, 2'b11, 8'h5A}, 10, 1'b0, rb, pz, tl);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    SS_n  = 1'b0;
    MOSI  = 1'b1;
    repeat (3) @(negedge clk);
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    total++;
    if (MISO !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b want=0", MISO); end
    total++;
    if (dut.state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dut.state); end
    total++;
    if (dut.rd_addr_flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%b want=0", dut.rd_addr_flag); end
    total++;
    if (dut.Memory.wr_addr !== 8'h00 || dut.Memory.rd_addr !== 8'h00) begin
      bad++; $display("FAIL reset_addr got=%h/%h want=00/00", dut.Memory.wr_addr, dut.Memory.rd_addr);
    end
    total++;
    if (dut.Memory.tx_valid !== 1'b0 || dut.Memory.dout !== 8'h00) begin
      bad++; $display("FAIL reset_tx got=%b/%h want=0/00", dut.Memory.tx_valid, dut.Memory.dout);
    end
  endtask

  task automatic test_basic_frames();
    logic [7:0] rb;
    logic pz, tl;
    send_frame({1'b0, 2'b00, 8'h69}, 0, 1'b0, rb, pz, tl);
    total++;
    if (dut.Memory.wr_addr !== 8'h69) begin bad++; $display("FAIL wr_addr got=%h want=69", dut.Memory.wr_addr); end
    send_frame({1'b0, 2'b01, 8'hB3}, 0, 1'b0, rb, pz, tl);
    total++;
    if (dut.Memory.Mem[8'h69] !== 8'hB3) begin bad++; $display("FAIL wr_data got=%h want=b3", dut.Memory.Mem[8'h69]); end
    send_frame({1'b1, 2'b10, 8'h69}, 0, 1'b0, rb, pz, tl);
    total++;
    if (dut.Memory.rd_addr !== 8'h69) begin bad++; $display("FAIL rd_addr got=%h want=69", dut.Memory.rd_addr); end
    total++;
    if (dut.rd_addr_flag !== 1'b1) begin bad++; $display("FAIL flag_set got=%b want=1", dut.rd_addr_flag); end
    send_frame({1'b1, 2'b11, 8'hC7}, 10, 1'b0, rb, pz, tl);
    total++;
    if (rb !== 8'hB3) begin bad++; $display("FAIL rd_miso got=%h want=b3", rb); end
    total++;
    if (pz !== 1'b1) begin bad++; $display("FAIL rd_miso_lead got=%b want=1", pz); end
    total++;
    if (tl !== 1'b0) begin bad++; $display("FAIL rd_miso_tail got=%b want=0", tl); end
    total++;
    if (dut.Memory.dout !== 8'hB3) begin bad++; $display("FAIL tx_data got=%h want=b3", dut.Memory.dout); end
    total++;
    if (dut.rd_addr_flag !== 1'b0) begin bad++; $display("FAIL flag_clr got=%b want=0", dut.rd_addr_flag); end
  endtask

  task automatic test_boundary();
    logic [7:0] rb;
    logic pz, tl;
    do_write(8'hFE, 8'h5C);
    do_write(8'hFF, 8'h01);
    total++;
    if (dut.Memory.Mem[8'hFF] !== 8'h01) begin bad++; $display("FAIL mem_ff got=%h want=01", dut.Memory.Mem[8'hFF]); end
    do_read(8'hFE, rb, pz, tl);
    total++;
    if (rb !== 8'h5C) begin bad++; $display("FAIL rd_fe got=%h want=5c", rb); end
    do_read(8'hFF, rb, pz, tl);
    total++;
    if (rb !== 8'h01) begin bad++; $display("FAIL rd_ff got=%h want=01", rb); end
    do_read(8'h00, rb, pz, tl);
    total++;
    if (rb !== 8'h00 && dut.Memory.Mem[8'h00] === 8'h00) begin bad++; $display("FAIL rd_00 got=%h want=00", rb); end
  endtask

  task automatic test_abort();
    logic [7:0] rb;
    logic pz, tl;
    do_write(8'h10, 8'h22);
    send_partial({1'b0, 2'b01, 8'h77}, 8);
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
    total++;
    if (dut.state !== 3'd0) begin bad++; $display("FAIL abort_state got=%0d want=0", dut.state); end
    @(negedge clk);
    total++;
    if (dut.Memory.Mem[8'h10] !== 8'h22) begin bad++; $display("FAIL abort_mem got=%h want=22", dut.Memory.Mem[8'h10]); end
    do_read(8'h10, rb, pz, tl);
    total++;
    if (rb !== 8'h22) begin bad++; $display("FAIL abort_rd got=%h want=22", rb); end
  endtask

  task automatic test_reset_midframe();
    send_partial({1'b0, 2'b01, 8'h99}, 10);
    @(negedge clk);
    rst_n = 1'b1;
    MOSI  = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (dut.Memory.Mem[8'h10] !== 8'h22) begin bad++; $display("FAIL rstmid_mem got=%h want=22", dut.Memory.Mem[8'h10]); end
    total++;
    if (dut.state !== 3'd0 || dut.Memory.wr_addr !== 8'h00) begin
      bad++; $display("FAIL rstmid_state got=%0d/%h want=0/00", dut.state, dut.Memory.wr_addr);
    end
  endtask

  task automatic test_extra_bits();
    logic [7:0] rb;
    logic pz, tl;
    send_frame({1'b0, 2'b00, 8'h30}, 0, 1'b0, rb, pz, tl);
    send_frame({1'b0, 2'b01, 8'h44}, 12, 1'b1, rb, pz, tl);
    total++;
    if (dut.Memory.Mem[8'h30] !== 8'h44) begin bad++; $display("FAIL extra_mem got=%h want=44", dut.Memory.Mem[8'h30]); end
    total++;
    if (dut.Memory.wr_addr !== 8'h30) begin bad++; $display("FAIL extra_addr got=%h want=30", dut.Memory.wr_addr); end
    total++;
    if (rb !== 8'h00 || tl !== 1'b0) begin bad++; $display("FAIL extra_miso got=%h/%b want=00/0", rb, tl); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    test_reset();
    test_basic_frames();
    test_boundary();
    test_abort();
    test_reset_midframe();
    test_extra_bits();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
